// File: rtl/bus_select_reg.sv
// bus_select_reg: registered multi-source bus with fixed-priority selection.
// Each cycle, the lowest-index asserted src_out bit wins. Its data is loaded
// into bus one clock later, and bus_src records the winner's index.
// If two or more sources ask for the bus in the same cycle, a conflict is
// flagged. A sticky flag records that any conflict has happened since the
// last clear.
// Optional feature: define BUSSEL_CONFLICT_CNT_EN to build an 8-bit
// saturating conflict counter. Without it, conflict_cnt is tied to zero.
module bus_select_reg #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 24,
  parameter int HOLD  = 1,
  localparam int SW   = $clog2(NSRC)
) (
  input  logic                  clock,
  input  logic                  clr_n,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_out,
  input  logic                  err_clr,
  output logic [WIDTH-1:0]      bus,
  output logic                  bus_valid,
  output logic [SW-1:0]         bus_src,
  output logic                  conflict,
  output logic                  conflict_sticky,
  output logic [7:0]            conflict_cnt
);

  logic             any_req;
  logic             multi_req;
  logic [SW-1:0]    win_idx;
  logic [WIDTH-1:0] win_data;

  // Fixed-priority winner select plus request and conflict detection.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    win_idx   = '0;
    win_data  = '0;
    any_req   = |src_out;
    // Clearing the lowest set bit leaves a nonzero value only when at least two bits are set.
    multi_req = |(src_out & (src_out - NSRC'(1)));
    // Walk from the top index down, so the lowest asserted index is written last and wins.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_out[i]) begin
        win_idx  = SW'(i);
        win_data = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Bus, source index and valid register; idle cycles either hold the bus or clear it.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      bus       <= '0;
      bus_valid <= 1'b0;
      bus_src   <= '0;
    end else if (any_req) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      bus       <= win_data;
      bus_src   <= win_idx;
      bus_valid <= 1'b1;
    end else begin
      bus_valid <= 1'b0;
      if (HOLD == 0) begin
        bus <= '0;
      end
    end
  end

  // Conflict pulse and sticky flag. err_clr overrides a same-cycle conflict for the sticky flag.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      conflict        <= 1'b0;
      conflict_sticky <= 1'b0;
    end else begin
      conflict <= multi_req;
      if (err_clr) begin
        conflict_sticky <= 1'b0;
      end else if (multi_req) begin
        conflict_sticky <= 1'b1;
      end
    end
  end

`ifdef BUSSEL_CONFLICT_CNT_EN
  logic [7:0] cnt_q;

  // Saturating conflict counter. err_clr wins over a same-cycle conflict.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= 8'd0;
    end else if (err_clr) begin
      cnt_q <= 8'd0;
    end else if (multi_req && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = 8'd0;
`endif

endmodule

// File: doc/bus_select_reg.md
BUS_SELECT_REG -- requirements
Module: bus_select_reg

Interface
REQ-001 Parameter WIDTH, default 32, data width of every source and of the bus.
REQ-002 Parameter NSRC, default 24, number of bus sources; legal range 2..64.
REQ-003 Parameter HOLD, default 1; 1 = bus holds its last value when no source drives, 0 = bus returns to zero.
REQ-004 Derived constant SW = $clog2(NSRC), width of the encoded source index.
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 clr_n  input  1  reset, asynchronous, active-low.
REQ-007 src_data  input  NSRC*WIDTH  flattened sources; source i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH].
REQ-008 src_out  input  NSRC  one-hot out-enable strobes from control unit (R0out, R1out, ... style); bit i requests source i.
REQ-009 err_clr  input  1  synchronous clear of sticky conflict flag and conflict counter.
REQ-010 bus  output  WIDTH  registered bus value.
REQ-011 bus_valid  output  1  high for the cycle following a cycle with any src_out bit set.
REQ-012 bus_src  output  SW  registered index of the source that drove bus.
REQ-013 conflict  output  1  registered, high for the cycle following a cycle with two or more src_out bits set.
REQ-014 conflict_sticky  output  1  set by any conflict, held until err_clr or reset.
REQ-015 conflict_cnt  output  8  saturating conflict count (see Configuration).

Function
REQ-016 Winner SHALL be the lowest-index asserted src_out bit (fixed priority, bit 0 highest).
REQ-017 On each rising edge with any src_out bit set: bus <= winner's data, bus_src <= winner index, bus_valid <= 1.
REQ-018 On a rising edge with src_out all zero: bus_valid <= 0, bus_src holds; bus holds if HOLD=1, bus <= 0 if HOLD=0.
REQ-019 Latency from src_out/src_data to bus SHALL be exactly one clock; no combinational path from inputs to any output.
REQ-020 conflict <= 1 when popcount(src_out) >= 2, else 0; bus still takes the lowest-index winner.
REQ-021 conflict_sticky SHALL set on the same edge conflict sets and SHALL NOT clear except via err_clr or clr_n.
REQ-022 conflict_cnt SHALL increment by 1 per conflicting cycle and saturate at 255 (no wrap).
REQ-023 err_clr and a conflict in the same cycle: err_clr wins; sticky and counter go to 0, conflict output still reports 1.
REQ-024 Source indices >= NSRC do not exist; bus_src SHALL never exceed NSRC-1.
REQ-025 All outputs SHALL be driven from flops; no latches.

Reset
REQ-026 clr_n low SHALL immediately force bus=0, bus_valid=0, bus_src=0, conflict=0, conflict_sticky=0, conflict_cnt=0, regardless of clock.
REQ-027 Reset asserted mid-transfer SHALL discard the in-flight value; first edge after clr_n rises SHALL behave per REQ-017/018.

Configuration
REQ-028 Macro BUSSEL_CONFLICT_CNT_EN defined: 8-bit saturating conflict counter implemented per REQ-022/023.
REQ-029 Macro BUSSEL_CONFLICT_CNT_EN undefined: no counter flops; conflict_cnt tied to 8'd0; conflict and conflict_sticky unaffected.

Verification
REQ-030 Reset: clr_n=0 with src_out=1 on bit 5 -> all outputs 0 during reset, no bus update.
REQ-031 Single source: src_out=1<<21, source 21 = 32'hDEAD_BEEF -> next edge bus=32'hDEAD_BEEF, bus_src=21, bus_valid=1, conflict=0.
REQ-032 Idle hold: after REQ-031, src_out=0 -> HOLD=1: bus stays 32'hDEAD_BEEF, bus_valid=0; HOLD=0: bus=0.
REQ-033 Conflict: src_out bits 3 and 16 set, source 3 = 32'h0000_0003 -> bus=32'h0000_0003, bus_src=3, conflict=1, conflict_sticky=1, conflict_cnt=1 (0 with macro undefined).
REQ-034 Saturation: 300 consecutive conflicting cycles -> conflict_cnt=255; then err_clr=1 with conflict -> sticky=0, cnt=0, conflict=1.
REQ-035 Parameter sweep: NSRC=2, WIDTH=8 and NSRC=64, WIDTH=64 -> highest-index source alone selects correctly, bus_src=NSRC-1.
